// File: rtl/gb_audio_pkg.sv
// Shared constants and types for the I2S audio transmitter: frame geometry,
// slot boundaries and the signed sample type.
package gb_audio_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int SLOT_BITS   = 32;
  localparam int FRAME_BITS  = 64;

  // Last bit index of the left and right slots within a frame.
  localparam logic [5:0] SLOT_L_END = 6'd31;
  localparam logic [5:0] SLOT_R_END = 6'd63;

  typedef logic signed [SAMPLE_BITS-1:0] audio_sample_t;

  // Serial bit for frame position k: sample MSB-first in the first 16 bits of
  // each slot, zero padding in the remaining 16.
  function automatic logic serial_bit(audio_sample_t l, audio_sample_t r,
                                      logic [5:0] k);
    logic [3:0] idx;
    idx = ~k[3:0];
    case (k[5:4])
      2'b00:   serial_bit = l[idx];
      2'b10:   serial_bit = r[idx];
      default: serial_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/i2s_audio_tx_bclk_gen.sv
// BCLK generator: divides clk by 2*BCLK_HALF using a clock enable and flags
// each BCLK falling edge with a one-cycle fe pulse.
module i2s_bclk_gen #(
  parameter int BCLK_HALF = 16
) (
  input  logic clk,
  input  logic rst,
  output logic i2s_bclk,
  output logic fe
);

  localparam int DW = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  always_comb begin
    wrap      = (div_cnt_q == DIV_LAST);
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = wrap ? ~bclk_q : bclk_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign i2s_bclk = bclk_q;
  // Gated by rst so no serial state or strobe can react during reset.
  assign fe       = wrap & bclk_q & ~rst;

endmodule

// File: rtl/i2s_audio_tx.sv
// Stereo I2S transmitter: latches a coherent left/right pair once per 64-BCLK
// frame and shifts it out MSB-first. Optional attenuation via AUDIO_VOLUME_EN.
module i2s_audio_tx
  import gb_audio_pkg::*;
#(
  parameter int BCLK_HALF = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
`ifdef AUDIO_VOLUME_EN
  input  logic [2:0]  volume,
`endif
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        sample_strobe
);

  logic          fe;
  logic [5:0]    bit_cnt_q, bit_cnt_d, bit_next;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  audio_sample_t lat_l_q, lat_l_d;
  audio_sample_t lat_r_q, lat_r_d;
  logic          latch;

  i2s_bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .clk      (clk),
    .rst      (rst),
    .i2s_bclk (i2s_bclk),
    .fe       (fe)
  );

  // NOTE: every signal gets a default at the top of always_comb; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    lat_l_d   = lat_l_q;
    lat_r_d   = lat_r_q;
    bit_next  = bit_cnt_q + 6'd1;
    latch     = fe && (bit_next == SLOT_R_END);

    if (fe) begin
      bit_cnt_d = bit_next;
      // Word select leads the data by one BCLK: high for bits 31..62.
      lrclk_d   = (bit_next >= SLOT_L_END) && (bit_next < SLOT_R_END);
      sdata_d   = serial_bit(lat_l_q, lat_r_q, bit_next);
    end

    if (latch) begin
`ifdef AUDIO_VOLUME_EN
      lat_l_d = audio_sample_t'($signed(audio_left)  >>> volume);
      lat_r_d = audio_sample_t'($signed(audio_right) >>> volume);
`else
      lat_l_d = audio_sample_t'(audio_left);
      lat_r_d = audio_sample_t'(audio_right);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= SLOT_R_END;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      lat_l_q   <= '0;
      lat_r_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      lat_l_q   <= lat_l_d;
      lat_r_q   <= lat_r_d;
    end
  end

  assign i2s_lrclk     = lrclk_q;
  assign i2s_sdata     = sdata_q;
  assign sample_strobe = latch;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx at BCLK_HALF=4 against a time-based
// model of the I2S frame. Volume steps run when AUDIO_VOLUME_EN is defined.
module tb_i2s_audio_tx;

  localparam int H     = 4;
  localparam int FRAME = 128 * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] audio_left  = '0;
  logic [15:0] audio_right = '0;
`ifdef AUDIO_VOLUME_EN
  logic [2:0]  volume = '0;
`endif
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe;

  i2s_audio_tx #(.BCLK_HALF(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .audio_left    (audio_left),
    .audio_right   (audio_right),
`ifdef AUDIO_VOLUME_EN
    .volume        (volume),
`endif
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_sdata     (i2s_sdata),
    .sample_strobe (sample_strobe)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int          n = 0;
  int          cur_bit = 63;
  int          last_strobe = -1;
  logic        strobe_next = 1'b0;
  logic        prev_bclk = 1'b0;
  logic [63:0] acc = '0;
  logic [63:0] last_frame = '0;
  logic [15:0] cap_l[$];
  logic [15:0] cap_r[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
  endtask

  function automatic logic [15:0] scaled(input logic [15:0] x);
`ifdef AUDIO_VOLUME_EN
    return 16'($signed(x) >>> volume);
`else
    return x;
`endif
  endfunction

  // Whole frame as seen on the wire, bit 63 first: {L, pad, R, pad}.
  function automatic logic [63:0] frame_word(input int fr);
    if (fr < 1 || fr > cap_l.size()) return '0;
    return {cap_l[fr-1], 16'h0000, cap_r[fr-1], 16'h0000};
  endfunction

  // One clk cycle: commit a predicted capture, advance, then compare at #1.
  task automatic step();
    int          m, bitn, fr;
    logic [63:0] fw;
    logic        eb, el, es, est;
    if (strobe_next) begin
      cap_l.push_back(scaled(audio_left));
      cap_r.push_back(scaled(audio_right));
    end
    @(posedge clk);
    n++;
    #1;
    m    = n / (2 * H);
    bitn = (m + 63) % 64;
    fr   = (m == 0) ? 0 : (m - 1) / 64;
    fw   = frame_word(fr);
    eb   = ((n / H) % 2) == 1;
    el   = (bitn >= 31) && (bitn <= 62);
    es   = fw[63 - bitn];
    est  = ((n + 1) % FRAME) == 0;
    check("bclk",   64'(i2s_bclk),      64'(eb));
    check("lrclk",  64'(i2s_lrclk),     64'(el));
    check("sdata",  64'(i2s_sdata),     64'(es));
    check("strobe", 64'(sample_strobe), 64'(est));
    if (!prev_bclk && i2s_bclk) begin
      acc = {acc[62:0], i2s_sdata};
      if (bitn == 63 && m >= 64) begin
        last_frame = acc;
        check("frame_decode", acc, fw);
      end
    end
    prev_bclk = i2s_bclk;
    if (sample_strobe) begin
      if (last_strobe >= 0) check("strobe_spacing", 64'(n - last_strobe), 64'(FRAME));
      last_strobe = n;
    end
    cur_bit     = bitn;
    strobe_next = est;
  endtask

  task automatic do_reset(input int cycles, input string tag);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    cur_bit = 63;
    last_strobe = -1;
    strobe_next = 1'b0;
    prev_bclk = 1'b0;
    cap_l.delete();
    cap_r.delete();
    check({tag, "_bclk"},   64'(i2s_bclk),      64'd0);
    check({tag, "_lrclk"},  64'(i2s_lrclk),     64'd0);
    check({tag, "_sdata"},  64'(i2s_sdata),     64'd0);
    check({tag, "_strobe"}, 64'(sample_strobe), 64'd0);
  endtask

  task automatic randomize_inputs();
    audio_left  = 16'($urandom);
    audio_right = 16'($urandom);
`ifdef AUDIO_VOLUME_EN
    volume = 3'($urandom_range(0, 7));
`endif
  endtask

  initial begin
    // Power-on reset, then a constant pair: frame 0 silent, frame 1 carries it.
    audio_left  = 16'hA5C3;
    audio_right = 16'h0F0F;
    do_reset(3, "reset");
    for (int i = 0; i < 2 * FRAME + 2 * H; i++) step();
    check("pattern_a5c3", last_frame, 64'hA5C3_0000_0F0F_0000);

    // Inputs churn every 3 clk; only the strobe-cycle values may be sent.
    for (int i = 0; i < 2 * FRAME + 4 * H; i++) begin
      if (i % 3 == 0) randomize_inputs();
      step();
    end

    // One-cycle reset pulse in the middle of the right slot.
    for (int i = 0; i < FRAME && cur_bit != 40; i++) step();
    check("reach_bit40", 64'(cur_bit), 64'd40);
    do_reset(1, "midrst");
    for (int i = 0; i < 2 * FRAME + 2 * H; i++) begin
      if (i % 3 == 0) randomize_inputs();
      step();
    end

`ifdef AUDIO_VOLUME_EN
    audio_left  = 16'h8000;
    audio_right = 16'h7FFF;
    volume      = 3'd2;
    for (int i = 0; i < 2 * FRAME + 2 * H; i++) step();
    check("volume_shift", last_frame, 64'hE000_0000_1FFF_0000);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
